// File: rtl/bird_collision_detect_if.sv
`default_nettype none
// ============================================================================
// Module      : bird_collision_detect_if
// Description : Game-side bundle between the playfield (bird/pipe columns,
//               start key, pipe advance strobe) and the collision/score
//               sequencer.
//               master : playfield side, drives start/bird_col/pipe_col/
//                        pipe_tick and observes status and score.
//               slave  : sequencer side, consumes the playfield signals and
//                        drives loss_detect/game_over/playing/score digits.
// Revision    : 1.0 - initial release
// ============================================================================
interface bird_collision_detect_if;
    logic       start;
    logic [7:0] bird_col;
    logic [7:0] pipe_col;
    logic       pipe_tick;
    logic       loss_detect;
    logic       game_over;
    logic       playing;
    logic [3:0] score_ones;
    logic [3:0] score_tens;

    modport master (
        output start, bird_col, pipe_col, pipe_tick,
        input  loss_detect, game_over, playing, score_ones, score_tens
    );

    modport slave (
        input  start, bird_col, pipe_col, pipe_tick,
        output loss_detect, game_over, playing, score_ones, score_tens
    );
endinterface
`default_nettype wire

// File: rtl/bird_collision_detect.sv
`default_nettype none
// ============================================================================
// Module      : bird_collision_detect
// Description : Compares the bird column against the pipe column at the bird's
//               x-position, detects the bird leaving the grid, keeps a
//               two-digit saturating BCD score and sequences the game through
//               IDLE -> PLAY -> LOSS (flash) -> OVER.
// Ports       : clock  - system clock
//               reset  - synchronous, active-high
//               bus    - slave side of bird_collision_detect_if
//                        (start, bird_col, pipe_col, pipe_tick in;
//                         loss_detect, game_over, playing, score digits out)
// Revision    : 1.0 - initial release
// ============================================================================
module bird_collision_detect #(
    parameter int EMPTY_LIMIT  = 3584,
    parameter int FLASH_CYCLES = 14336,
    parameter int CNT_W        = 14
) (
    input  wire logic              clock,
    input  wire logic              reset,
    bird_collision_detect_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_LOSS = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_empty_last = CNT_W'(EMPTY_LIMIT - 1);
    localparam logic [CNT_W-1:0] c_flash_last = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_ones;
    logic [3:0]       r_tens;
    logic             w_score_inc;
    logic             w_score_clr;
    logic             w_hit;
    logic             w_score_max;

    assign w_hit       = |(bus.bird_col & bus.pipe_col);
    assign w_score_max = (r_tens == 4'd9) && (r_ones == 4'd9);

    // State, cycle counter and score registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_score_clr) begin
                r_ones <= 4'd0;
                r_tens <= 4'd0;
            end else if (w_score_inc && !w_score_max) begin
                if (r_ones == 4'd9) begin
                    r_ones <= 4'd0;
                    r_tens <= r_tens + 4'd1;
                end else begin
                    r_ones <= r_ones + 4'd1;
                end
            end
        end
    end

    // Next-state, counter and score control.
    // The counter is shared: in PLAY it measures consecutive empty-column
    // cycles, in LOSS it times the flash period.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_score_inc  = 1'b0;
        w_score_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_PLAY;
                    w_cnt_next   = '0;
                    w_score_clr  = 1'b1;
                end
            end
            S_PLAY: begin
                if (w_hit) begin
                    // A collision takes precedence over a same-cycle pipe pass.
                    w_state_next = S_LOSS;
                    w_cnt_next   = '0;
                end else if (bus.bird_col == 8'h00) begin
                    if (r_cnt == c_empty_last) begin
                        w_state_next = S_LOSS;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_cnt_one;
                    end
                end else begin
                    w_cnt_next = '0;
                    if (bus.pipe_tick && (bus.pipe_col != 8'h00)) begin
                        w_score_inc = 1'b1;
                    end
                end
            end
            S_LOSS: begin
                if (r_cnt == c_flash_last) begin
                    w_state_next = S_OVER;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    w_state_next = S_PLAY;
                    w_cnt_next   = '0;
                    w_score_clr  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.playing     = (r_state == S_PLAY);
    assign bus.loss_detect = (r_state == S_LOSS) || (r_state == S_OVER);
    assign bus.game_over   = (r_state == S_OVER);
    assign bus.score_ones  = r_ones;
    assign bus.score_tens  = r_tens;

endmodule
`default_nettype wire

// File: doc/bird_collision_detect.md
Name: bird_collision_detect

Overview:
- Downstream consumer of the eight bird-column light cells; drives their shared lossDetect input.
- Compares the bird column against the pipe column occupying the bird's x-position, and detects the bird leaving the grid (all cells dark too long).
- Keeps a two-digit BCD score for the HEX displays.
- Sequences the game: idle, play, loss flash, game over.

Parameters:
- EMPTY_LIMIT, 3584: consecutive clock cycles with bird_col==0 during PLAY that trigger loss (two bird update periods of 1792).
- FLASH_CYCLES, 14336: cycles spent in LOSS before entering OVER (eight bird periods).
- CNT_W, 14: width of the internal cycle counter; must hold max(EMPTY_LIMIT, FLASH_CYCLES).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high; reset reset, synchronous, active-high; clock clock
- start  input  1  one-cycle pulse from debounced key press
- bird_col  input  8  lightOn of the bird column, bit 0 = bottom row
- pipe_col  input  8  pipe cells in the bird's column, bit 0 = bottom row
- pipe_tick  input  1  one-cycle pulse when pipes advance one column
- loss_detect  output  1  drives lossDetect of every bird cell
- game_over  output  1  high in OVER only
- playing  output  1  high in PLAY only
- score_ones  output  4  BCD ones digit
- score_tens  output  4  BCD tens digit

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset (any cycle, including mid-game): state=IDLE, cnt=0, score=00. All outputs 0.
- States: IDLE, PLAY, LOSS, OVER (2-bit encoding).
- IDLE: start -> PLAY with score=00 and cnt=0. Otherwise hold.
- PLAY (playing=1):
  - hit = |(bird_col & pipe_col), sampled each cycle.
  - If hit -> LOSS next cycle with cnt=0. Any pipe_tick in the same cycle is ignored; no score.
  - Else if bird_col==0: cnt++. When cnt reaches EMPTY_LIMIT-1 while still empty -> LOSS with cnt=0. Loss therefore occurs on the EMPTY_LIMIT-th consecutive empty cycle.
  - A nonzero bird_col resets cnt to 0.
  - Else if pipe_tick && pipe_col!=0 (pipe leaves cleanly): score increments on the next edge.
  - Loss is asserted the cycle after the offending sample (1-cycle latency).
  - start is ignored in PLAY.
- Score is BCD:
  - ones 9 -> 0 with tens +1.
  - Saturates at 99; further passes hold 99.
  - Digits never take values 10-15.
- LOSS (loss_detect=1): cnt++ each cycle. At cnt==FLASH_CYCLES-1 -> OVER. start is ignored. Score is frozen.
- OVER (loss_detect=1, game_over=1):
  - Score is held.
  - start -> PLAY next cycle, with score=00, cnt=0, loss_detect=0.
- Output decode: playing=(PLAY), loss_detect=(LOSS|OVER), game_over=(OVER).
- Simultaneous start and reset: reset wins.
- pipe_tick outside PLAY has no effect.

Test Plan:
- Reset, then start pulse -> playing=1 the next cycle, score 00. Hold bird_col=8'h10, pipe_col=8'h0F, pulse pipe_tick -> score 01 one cycle later, loss_detect stays 0.
- PLAY, bird_col=8'h08, pipe_col=8'h08 with pipe_tick the same cycle -> loss_detect=1 the next cycle, score unchanged. After FLASH_CYCLES cycles -> game_over=1.
- PLAY, bird_col=0 for EMPTY_LIMIT-1 cycles then 8'h01 -> no loss, cnt cleared. Then bird_col=0 for EMPTY_LIMIT cycles -> loss_detect rises.
- 105 clean pipe passes -> score goes 09 -> 10 at the 10th pass, reaches 99 at the 99th, and stays 99 through pass 105.
- OVER with score 37, start pulse -> playing=1, loss_detect=0, game_over=0, score 00. Start pulses during LOSS have no effect.
- Reset asserted mid-PLAY with score 12 -> next cycle all outputs 0, state IDLE. pipe_tick in IDLE leaves score at 00.
